// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_sb_pkg;

   localparam int DW_DEF       = 16;
   localparam int AW_DEF       = 4;
   localparam int ZERO_REG_DEF = 0;
   localparam int BYPASS_DEF   = 1;
   localparam int REG0_ADDR    = 0;

   // True when the address targets the hardwired-zero register and that feature is on.
   function automatic logic hits_zero_reg(input logic zero_reg_en, input logic [31:0] addr);
      return zero_reg_en && (addr == 32'(REG0_ADDR));
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle of the register file: two write ports, two read ports, issue/flush and busy status.
interface regfile_sb_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic          we1;
   logic [AW-1:0] wa1;
   logic [DW-1:0] wd1;
   logic          we2;
   logic [AW-1:0] wa2;
   logic [DW-1:0] wd2;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   logic          iss;
   logic [AW-1:0] iss_a;
   logic          flush;
   logic          busy1;
   logic          busy2;
   logic [AW:0]   busy_cnt;

   modport master (
      output we1, wa1, wd1, we2, wa2, wd2, ra1, ra2, iss, iss_a, flush,
      input  rd1, rd2, busy1, busy2, busy_cnt
   );

   modport slave (
      input  we1, wa1, wd1, we2, wa2, wd2, ra1, ra2, iss, iss_a, flush,
      output rd1, rd2, busy1, busy2, busy_cnt
   );
endinterface

// File: rtl/regfile_sb_score.sv
// Busy scoreboard: one flag per register plus a registered population count.
// Priority each cycle: flush > issue (new producer) > write-back clear.
module regfile_sb_score
   import regfile_sb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF,
   parameter int BYPASS   = BYPASS_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          iss,
   input  logic [AW-1:0] iss_a,
   input  logic          clr1,
   input  logic [AW-1:0] ca1,
   input  logic          clr2,
   input  logic [AW-1:0] ca2,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic          busy1,
   output logic          busy2,
   output logic [AW:0]   busy_cnt
);
   localparam int DEPTH = 2**AW;

   logic [DEPTH-1:0] busy_r;
   logic [DEPTH-1:0] busy_nxt_s;
   logic [AW:0]      cnt_r;
   logic [AW:0]      cnt_nxt_s;
   logic             set_s;
   logic             fwd1_s;
   logic             fwd2_s;

   // Issue is dropped when it targets the hardwired-zero register.
   always_comb begin
      set_s = iss && !hits_zero_reg(ZERO_REG != 0, 32'(iss_a));
   end

   // Next busy vector and its population count.
   always_comb begin
      busy_nxt_s = busy_r;
      cnt_nxt_s  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush) begin
            busy_nxt_s[i] = 1'b0;
         end else if (set_s && (iss_a == AW'(i))) begin
            busy_nxt_s[i] = 1'b1;
         end else if ((clr1 && (ca1 == AW'(i))) || (clr2 && (ca2 == AW'(i)))) begin
            busy_nxt_s[i] = 1'b0;
         end else begin
            busy_nxt_s[i] = busy_r[i];
         end
         cnt_nxt_s = cnt_nxt_s + (AW+1)'(busy_nxt_s[i]);
      end
   end

   // Busy flags and count state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r <= '0;
         cnt_r  <= '0;
      end else begin
         busy_r <= busy_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

   // Same-cycle write-back hits on the read addresses, unless a new producer issues there.
   always_comb begin
      fwd1_s = (BYPASS != 0) && ((clr1 && (ca1 == ra1)) || (clr2 && (ca2 == ra1)))
               && !(iss && (iss_a == ra1));
      fwd2_s = (BYPASS != 0) && ((clr1 && (ca1 == ra2)) || (clr2 && (ca2 == ra2)))
               && !(iss && (iss_a == ra2));
   end

   // Busy status towards the read ports, held low during reset.
   always_comb begin
      if (!rst) begin
         busy1 = 1'b0;
         busy2 = 1'b0;
      end else begin
         busy1 = fwd1_s ? 1'b0 : busy_r[ra1];
         busy2 = fwd2_s ? 1'b0 : busy_r[ra2];
      end
   end

   assign busy_cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// N-deep, W-wide register file with two write ports, two read ports,
// optional write->read bypass, optional hardwired-zero reg 0 and a busy scoreboard.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF,
   parameter int BYPASS   = BYPASS_DEF
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);
   localparam int DEPTH = 2**AW;

   logic [DW-1:0] mem_r [DEPTH];
   logic          acc1_s;
   logic          acc2_s;
   logic [DW-1:0] rd1_s;
   logic [DW-1:0] rd2_s;

   // Write arbitration: port 1 wins an address collision; reg-0 writes vanish when hardwired.
   always_comb begin
      acc1_s = bus.we1 && !hits_zero_reg(ZERO_REG != 0, 32'(bus.wa1));
      acc2_s = bus.we2 && !(bus.we1 && (bus.wa1 == bus.wa2))
               && !hits_zero_reg(ZERO_REG != 0, 32'(bus.wa2));
   end

   // Data array update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (acc1_s) begin
            mem_r[bus.wa1] <= bus.wd1;
         end
         if (acc2_s) begin
            mem_r[bus.wa2] <= bus.wd2;
         end
      end
   end

   // Read port 1: reset gate, zero register, then bypass (port 1 before port 2), then array.
   always_comb begin
      if (!rst) begin
         rd1_s = '0;
      end else if (hits_zero_reg(ZERO_REG != 0, 32'(bus.ra1))) begin
         rd1_s = '0;
      end else if ((BYPASS != 0) && acc1_s && (bus.wa1 == bus.ra1)) begin
         rd1_s = bus.wd1;
      end else if ((BYPASS != 0) && acc2_s && (bus.wa2 == bus.ra1)) begin
         rd1_s = bus.wd2;
      end else begin
         rd1_s = mem_r[bus.ra1];
      end
   end

   // Read port 2: same selection order as port 1.
   always_comb begin
      if (!rst) begin
         rd2_s = '0;
      end else if (hits_zero_reg(ZERO_REG != 0, 32'(bus.ra2))) begin
         rd2_s = '0;
      end else if ((BYPASS != 0) && acc1_s && (bus.wa1 == bus.ra2)) begin
         rd2_s = bus.wd1;
      end else if ((BYPASS != 0) && acc2_s && (bus.wa2 == bus.ra2)) begin
         rd2_s = bus.wd2;
      end else begin
         rd2_s = mem_r[bus.ra2];
      end
   end

   assign bus.rd1 = rd1_s;
   assign bus.rd2 = rd2_s;

   regfile_sb_score #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_score (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush),
      .iss      (bus.iss),
      .iss_a    (bus.iss_a),
      .clr1     (acc1_s),
      .ca1      (bus.wa1),
      .clr2     (acc2_s),
      .ca2      (bus.wa2),
      .ra1      (bus.ra1),
      .ra2      (bus.ra2),
      .busy1    (bus.busy1),
      .busy2    (bus.busy2),
      .busy_cnt (bus.busy_cnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: dut_a (BYPASS=1, ZERO_REG=0) runs a vector table plus flush/reset
// sequences; dut_b (BYPASS=0, ZERO_REG=1) runs hand-written sequences.
module tb_regfile_sb;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   regfile_sb_if #(.DW(16), .AW(4)) bus_a ();
   regfile_sb_if #(.DW(16), .AW(4)) bus_b ();

   regfile_sb #(.DW(16), .AW(4), .ZERO_REG(0), .BYPASS(1)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a)
   );
   regfile_sb #(.DW(16), .AW(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b)
   );

   typedef struct {
      logic        we1; logic [3:0] wa1; logic [15:0] wd1;
      logic        we2; logic [3:0] wa2; logic [15:0] wd2;
      logic [3:0]  ra1; logic [3:0] ra2;
      logic        iss; logic [3:0] iss_a;
      logic        flush;
      logic [15:0] e_rd1; logic [15:0] e_rd2;
      logic        e_b1;  logic e_b2;
      logic [4:0]  e_cnt;
   } vec_t;

   vec_t v [25];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_a();
      bus_a.we1 = 1'b0; bus_a.wa1 = 4'd0; bus_a.wd1 = 16'h0000;
      bus_a.we2 = 1'b0; bus_a.wa2 = 4'd0; bus_a.wd2 = 16'h0000;
      bus_a.iss = 1'b0; bus_a.iss_a = 4'd0; bus_a.flush = 1'b0;
   endtask

   task automatic idle_b();
      bus_b.we1 = 1'b0; bus_b.wa1 = 4'd0; bus_b.wd1 = 16'h0000;
      bus_b.we2 = 1'b0; bus_b.wa2 = 4'd0; bus_b.wd2 = 16'h0000;
      bus_b.iss = 1'b0; bus_b.iss_a = 4'd0; bus_b.flush = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      //            we1  wa1   wd1       we2  wa2   wd2       ra1   ra2   iss  iss_a flush  rd1       rd2       b1    b2    cnt
      v[0]  = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd0, 4'd0, 1'b0,4'd0, 1'b0, 16'h0000,16'h0000,1'b0,1'b0,5'd0};
      v[1]  = '{1'b1,4'd1, 16'hAAAA,1'b0,4'd0, 16'h0000,4'd1, 4'd5, 1'b0,4'd0, 1'b0, 16'hAAAA,16'h0000,1'b0,1'b0,5'd0};
      v[2]  = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd1, 4'd0, 1'b0,4'd0, 1'b0, 16'hAAAA,16'h0000,1'b0,1'b0,5'd0};
      v[3]  = '{1'b1,4'd3, 16'h1111,1'b1,4'd3, 16'h2222,4'd3, 4'd3, 1'b0,4'd0, 1'b0, 16'h1111,16'h1111,1'b0,1'b0,5'd0};
      v[4]  = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd3, 4'd1, 1'b0,4'd0, 1'b0, 16'h1111,16'hAAAA,1'b0,1'b0,5'd0};
      v[5]  = '{1'b1,4'd4, 16'h4444,1'b1,4'd5, 16'h5555,4'd4, 4'd5, 1'b0,4'd0, 1'b0, 16'h4444,16'h5555,1'b0,1'b0,5'd0};
      v[6]  = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd4, 4'd5, 1'b0,4'd0, 1'b0, 16'h4444,16'h5555,1'b0,1'b0,5'd0};
      v[7]  = '{1'b1,4'd2, 16'hCCCC,1'b0,4'd0, 16'h0000,4'd1, 4'd2, 1'b0,4'd0, 1'b0, 16'hAAAA,16'hCCCC,1'b0,1'b0,5'd0};
      v[8]  = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd6, 4'd7, 1'b1,4'd6, 1'b0, 16'h0000,16'h0000,1'b0,1'b0,5'd0};
      v[9]  = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd6, 4'd7, 1'b1,4'd7, 1'b0, 16'h0000,16'h0000,1'b1,1'b0,5'd1};
      v[10] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd6, 4'd7, 1'b0,4'd0, 1'b0, 16'h0000,16'h0000,1'b1,1'b1,5'd2};
      v[11] = '{1'b0,4'd0, 16'h0000,1'b1,4'd6, 16'h6666,4'd6, 4'd7, 1'b0,4'd0, 1'b0, 16'h6666,16'h0000,1'b0,1'b1,5'd2};
      v[12] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd6, 4'd7, 1'b0,4'd0, 1'b0, 16'h6666,16'h0000,1'b0,1'b1,5'd1};
      v[13] = '{1'b1,4'd7, 16'h7777,1'b0,4'd0, 16'h0000,4'd7, 4'd6, 1'b1,4'd7, 1'b0, 16'h7777,16'h6666,1'b1,1'b0,5'd1};
      v[14] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd7, 4'd6, 1'b0,4'd0, 1'b0, 16'h7777,16'h6666,1'b1,1'b0,5'd1};
      v[15] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd8, 4'd7, 1'b1,4'd8, 1'b0, 16'h0000,16'h7777,1'b0,1'b1,5'd1};
      v[16] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd8, 4'd7, 1'b1,4'd9, 1'b0, 16'h0000,16'h7777,1'b1,1'b1,5'd2};
      v[17] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd9, 4'd8, 1'b0,4'd0, 1'b0, 16'h0000,16'h0000,1'b1,1'b1,5'd3};
      v[18] = '{1'b1,4'd11,16'hBBBB,1'b0,4'd0, 16'h0000,4'd9, 4'd11,1'b1,4'd10,1'b1, 16'h0000,16'hBBBB,1'b1,1'b0,5'd3};
      v[19] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd9, 4'd10,1'b0,4'd0, 1'b0, 16'h0000,16'h0000,1'b0,1'b0,5'd0};
      v[20] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd12,4'd11,1'b1,4'd12,1'b0, 16'h0000,16'hBBBB,1'b0,1'b0,5'd0};
      v[21] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd12,4'd11,1'b1,4'd12,1'b0, 16'h0000,16'hBBBB,1'b1,1'b0,5'd1};
      v[22] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd12,4'd11,1'b0,4'd0, 1'b0, 16'h0000,16'hBBBB,1'b1,1'b0,5'd1};
      v[23] = '{1'b0,4'd0, 16'h0000,1'b1,4'd13,16'hD00D,4'd13,4'd12,1'b0,4'd0, 1'b0, 16'hD00D,16'h0000,1'b0,1'b1,5'd1};
      v[24] = '{1'b0,4'd0, 16'h0000,1'b0,4'd0, 16'h0000,4'd13,4'd11,1'b0,4'd0, 1'b0, 16'hD00D,16'hBBBB,1'b0,1'b0,5'd1};

      // Reset state
      rst = 1'b0;
      idle_a(); idle_b();
      bus_a.ra1 = 4'd1; bus_a.ra2 = 4'd2;
      bus_b.ra1 = 4'd1; bus_b.ra2 = 4'd2;
      #12;
      check("reset_rd1", 32'(bus_a.rd1), 32'h0);
      check("reset_rd2", 32'(bus_a.rd2), 32'h0);
      check("reset_cnt", 32'(bus_a.busy_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Vector table on dut_a
      for (int i = 0; i < 25; i++) begin
         next_cycle();
         bus_a.we1 = v[i].we1; bus_a.wa1 = v[i].wa1; bus_a.wd1 = v[i].wd1;
         bus_a.we2 = v[i].we2; bus_a.wa2 = v[i].wa2; bus_a.wd2 = v[i].wd2;
         bus_a.ra1 = v[i].ra1; bus_a.ra2 = v[i].ra2;
         bus_a.iss = v[i].iss; bus_a.iss_a = v[i].iss_a; bus_a.flush = v[i].flush;
         @(negedge clk);
         check($sformatf("v%0d_rd1", i), 32'(bus_a.rd1), 32'(v[i].e_rd1));
         check($sformatf("v%0d_rd2", i), 32'(bus_a.rd2), 32'(v[i].e_rd2));
         check($sformatf("v%0d_busy1", i), 32'(bus_a.busy1), 32'(v[i].e_b1));
         check($sformatf("v%0d_busy2", i), 32'(bus_a.busy2), 32'(v[i].e_b2));
         check($sformatf("v%0d_cnt", i), 32'(bus_a.busy_cnt), 32'(v[i].e_cnt));
      end
      next_cycle();
      idle_a();

      // dut_b: no bypass, hardwired reg 0
      bus_b.we1 = 1'b1; bus_b.wa1 = 4'd2; bus_b.wd1 = 16'h1234; bus_b.ra1 = 4'd2;
      @(negedge clk);
      check("b_nobypass_rd1", 32'(bus_b.rd1), 32'h0);
      next_cycle();
      bus_b.wd1 = 16'hCCCC; bus_b.ra2 = 4'd2;
      @(negedge clk);
      check("b_old_rd2", 32'(bus_b.rd2), 32'h1234);
      next_cycle();
      bus_b.we1 = 1'b0;
      @(negedge clk);
      check("b_new_rd2", 32'(bus_b.rd2), 32'hCCCC);
      next_cycle();
      bus_b.we1 = 1'b1; bus_b.wa1 = 4'd0; bus_b.wd1 = 16'hFFFF; bus_b.ra1 = 4'd0;
      bus_b.iss = 1'b1; bus_b.iss_a = 4'd0;
      @(negedge clk);
      check("b_zero_rd1_same", 32'(bus_b.rd1), 32'h0);
      next_cycle();
      bus_b.we1 = 1'b0; bus_b.iss_a = 4'd5;
      @(negedge clk);
      check("b_zero_rd1_next", 32'(bus_b.rd1), 32'h0);
      check("b_zero_iss_cnt", 32'(bus_b.busy_cnt), 32'h0);
      next_cycle();
      bus_b.iss = 1'b0; bus_b.ra1 = 4'd5;
      @(negedge clk);
      check("b_busy5", 32'(bus_b.busy1), 32'h1);
      check("b_cnt1", 32'(bus_b.busy_cnt), 32'h1);
      next_cycle();
      bus_b.we2 = 1'b1; bus_b.wa2 = 4'd5; bus_b.wd2 = 16'h5A5A;
      @(negedge clk);
      check("b_busy_noclr_fwd", 32'(bus_b.busy1), 32'h1);
      check("b_rd1_old", 32'(bus_b.rd1), 32'h0);
      next_cycle();
      idle_b();
      @(negedge clk);
      check("b_busy_cleared", 32'(bus_b.busy1), 32'h0);
      check("b_cnt0", 32'(bus_b.busy_cnt), 32'h0);
      check("b_rd1_stored", 32'(bus_b.rd1), 32'h5A5A);

      // dut_a: flush with three busy (12 already, plus 14 and 15)
      next_cycle();
      bus_a.iss = 1'b1; bus_a.iss_a = 4'd14;
      next_cycle();
      bus_a.iss_a = 4'd15;
      next_cycle();
      bus_a.iss = 1'b0; bus_a.ra1 = 4'd12;
      @(negedge clk);
      check("a_cnt3", 32'(bus_a.busy_cnt), 32'h3);
      next_cycle();
      bus_a.flush = 1'b1; bus_a.iss = 1'b1; bus_a.iss_a = 4'd1;
      next_cycle();
      bus_a.flush = 1'b0; bus_a.iss = 1'b0;
      @(negedge clk);
      check("a_flush_cnt", 32'(bus_a.busy_cnt), 32'h0);
      check("a_flush_busy1", 32'(bus_a.busy1), 32'h0);

      // Re-issue two, then reset in mid-cycle
      next_cycle();
      bus_a.iss = 1'b1; bus_a.iss_a = 4'd1;
      next_cycle();
      bus_a.iss_a = 4'd2;
      next_cycle();
      bus_a.iss = 1'b0; bus_a.ra1 = 4'd13; bus_a.ra2 = 4'd1;
      @(negedge clk);
      check("a_reissue_cnt", 32'(bus_a.busy_cnt), 32'h2);
      check("a_pre_rst_rd1", 32'(bus_a.rd1), 32'hD00D);
      next_cycle();
      #1;
      rst = 1'b0;
      bus_a.we1 = 1'b1; bus_a.wa1 = 4'd13; bus_a.wd1 = 16'hFFFF;
      #1;
      check("a_rst_cnt", 32'(bus_a.busy_cnt), 32'h0);
      check("a_rst_rd1", 32'(bus_a.rd1), 32'h0);
      check("a_rst_busy2", 32'(bus_a.busy2), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle_a();
      @(negedge clk);
      check("a_post_rst_rd1", 32'(bus_a.rd1), 32'h0);
      check("a_post_rst_cnt", 32'(bus_a.busy_cnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
